// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, FSM states and op encoding for the line memory interface
package mem_if_pkg;

    localparam int LINE_W  = 128;
    localparam int MADDR_W = 28;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        COOL
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

endpackage

// File: rtl/mem_line_ram.sv
// rtl/mem_line_ram.sv - single-port line array, write-first, registered read output
module mem_line_ram
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] rdata_d;

    // Output register only moves when the port is enabled, so it holds between accesses.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = we ? wdata : mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency 128-bit line memory responder for cache refill/write-back
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic               clk,
    input  logic               proc_reset_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [MADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]  mem_wdata,
    output logic [LINE_W-1:0]  mem_rdata,
    output logic               mem_ready,
    output logic               busy,
    output logic               err
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    op_e                   op_q, op_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic                  req;
    logic                  ram_en;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [LINE_W-1:0]     ram_wdata;
    logic                  unused_addr_hi;

    assign req            = mem_read | mem_write;
    assign unused_addr_hi = ^mem_addr[MADDR_W-1:DEPTH_LOG2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        ready_d   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = idx_q;
        ram_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = mem_addr[DEPTH_LOG2-1:0];
                    wdata_d = mem_wdata;
                    op_d    = mem_write ? OP_WR : OP_RD;
                    if (mem_read && mem_write) begin
                        err_d = 1'b1;
                    end
                    // With unit latency the response edge is the acceptance edge, so use live inputs.
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        cnt_d     = '0;
                        ready_d   = 1'b1;
                        ram_en    = 1'b1;
                        ram_we    = mem_write;
                        ram_addr  = mem_addr[DEPTH_LOG2-1:0];
                        ram_wdata = mem_wdata;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    ram_en  = 1'b1;
                    ram_we  = (op_q == OP_WR);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = COOL;
            end
            COOL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= OP_RD;
            wdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    mem_line_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .resetn(proc_reset_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (mem_rdata)
    );

    assign mem_ready = ready_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - directed and randomized check of mem_line_responder at LATENCY 4 and 1
module tb_mem_line_responder;

    localparam int BIG = 32'h3fff_ffff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [27:0]  mem_addr = '0;
    logic [127:0] mem_wdata = '0;

    logic [127:0] rdata_a, rdata_b;
    logic         ready_a, ready_b, busy_a, busy_b, err_a, err_b;

    mem_line_responder #(.LATENCY(4), .DEPTH_LOG2(8)) dut_a (
        .clk(clk), .proc_reset_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata_a),
        .mem_ready(ready_a), .busy(busy_a), .err(err_a)
    );

    mem_line_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_b (
        .clk(clk), .proc_reset_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata_b),
        .mem_ready(ready_b), .busy(busy_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    // Reference model: request timing as cycle arithmetic, storage as a plain array.
    int           lat [2];
    int           idle_from [2];
    bit           pend [2];
    int           acc [2];
    int           resp_at [2];
    logic [7:0]   p_idx [2];
    bit           p_wr [2];
    logic [127:0] p_wd [2];
    logic [127:0] m_rdata [2];
    bit           m_rknown [2];
    bit           m_err [2];
    logic [127:0] mmem [2][256];
    bit           mknown [2][256];

    bit           s_rdy [2];
    bit           s_busy [2];
    bit           s_err [2];
    logic [127:0] s_rdata [2];

    int           t_rdy_at [2];
    int           t_nrdy [2];
    logic [127:0] t_rdat [2];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k]      = 1'b0;
            idle_from[k] = 0;
            resp_at[k]   = -1;
            m_rdata[k]   = '0;
            m_rknown[k]  = 1'b1;
            m_err[k]     = 1'b0;
        end
    endtask

    task automatic model_commit(input int k, input int c);
        if (p_wr[k]) begin
            mmem[k][p_idx[k]]   = p_wd[k];
            mknown[k][p_idx[k]] = 1'b1;
            m_rdata[k]          = p_wd[k];
            m_rknown[k]         = 1'b1;
        end else begin
            m_rdata[k]  = mmem[k][p_idx[k]];
            m_rknown[k] = mknown[k][p_idx[k]];
        end
        resp_at[k]   = c + 1;
        idle_from[k] = c + 3;
    endtask

    task automatic model_update(input int k, input bit rd, input bit wr,
                                input logic [27:0] a, input logic [127:0] d);
        int c;
        c = cyc_n;
        if (!pend[k] && c >= idle_from[k]) begin
            if (rd || wr) begin
                p_idx[k] = a[7:0];
                p_wr[k]  = wr;
                p_wd[k]  = d;
                acc[k]   = c;
                if (rd && wr) m_err[k] = 1'b1;
                if (lat[k] == 1) begin
                    model_commit(k, c);
                end else begin
                    pend[k]      = 1'b1;
                    idle_from[k] = BIG;
                end
            end
        end else if (pend[k]) begin
            if (!(rd || wr)) begin
                pend[k]      = 1'b0;
                idle_from[k] = c + 1;
            end else if (c == acc[k] + lat[k] - 1) begin
                pend[k] = 1'b0;
                model_commit(k, c);
            end
        end
    endtask

    task automatic model_compare(input int k);
        check_eq($sformatf("ready%0d", k), 128'(s_rdy[k]), 128'(resp_at[k] == cyc_n));
        check_eq($sformatf("busy%0d", k), 128'(s_busy[k]), 128'(cyc_n < idle_from[k]));
        check_eq($sformatf("err%0d", k), 128'(s_err[k]), 128'(m_err[k]));
        if (m_rknown[k]) check_eq($sformatf("rdata%0d", k), s_rdata[k], m_rdata[k]);
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        @(negedge clk);
        s_rdy[0] = ready_a;  s_busy[0] = busy_a;  s_err[0] = err_a;  s_rdata[0] = rdata_a;
        s_rdy[1] = ready_b;  s_busy[1] = busy_b;  s_err[1] = err_b;  s_rdata[1] = rdata_b;
        for (int k = 0; k < 2; k++) begin
            model_compare(k);
            model_update(k, rd, wr, a, d);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Called just after a rising edge; reset is asserted mid-cycle and released on the falling edge.
    task automatic async_reset();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("rst_ready_a", 128'(ready_a), 128'(0));
        check_eq("rst_busy_a", 128'(busy_a), 128'(0));
        check_eq("rst_err_a", 128'(err_a), 128'(0));
        check_eq("rst_rdata_a", rdata_a, 128'(0));
        check_eq("rst_ready_b", 128'(ready_b), 128'(0));
        check_eq("rst_busy_b", 128'(busy_b), 128'(0));
        check_eq("rst_rdata_b", rdata_b, 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                       input int hold, input int tail);
        for (int k = 0; k < 2; k++) begin
            t_rdy_at[k] = -1;
            t_nrdy[k]   = 0;
            t_rdat[k]   = '0;
        end
        for (int i = 0; i < hold + tail; i++) begin
            if (i < hold) cyc(rd, wr, a, d);
            else cyc(1'b0, 1'b0, a, d);
            for (int k = 0; k < 2; k++) begin
                if (s_rdy[k]) begin
                    if (t_rdy_at[k] < 0) begin
                        t_rdy_at[k] = i;
                        t_rdat[k]   = s_rdata[k];
                    end
                    t_nrdy[k]++;
                end
            end
        end
    endtask

    function automatic logic [27:0] rnd_addr();
        logic [31:0] r;
        r = $urandom();
        return {r[27:8], 4'h0, r[3:0]};
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] d1, e1, f1, g1, h1, j1;
        int c0, c1, r0, r1;
        lat[0] = 4;
        lat[1] = 1;
        d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        e1 = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
        f1 = 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0;
        g1 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FACE_B00C;
        h1 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
        j1 = 128'h1357_9BDF_2468_ACE0_FFFF_0000_FFFF_0000;

        repeat (3) @(posedge clk);
        #1;
        async_reset();

        // Write 0x5: ready only in cycle 4, busy still high in COOL (cycle 5), low in cycle 6.
        txn(1'b0, 1'b1, 28'h0000005, d1, 5, 1);
        check_eq("wr5_ready_cycle", 128'(t_rdy_at[0]), 128'(4));
        check_eq("wr5_ready_count", 128'(t_nrdy[0]), 128'(1));
        check_eq("wr5_busy_cool", 128'(s_busy[0]), 128'(1));
        check_eq("lat1_ready_cycle", 128'(t_rdy_at[1]), 128'(1));
        cyc(1'b0, 1'b0, '0, '0);
        check_eq("wr5_busy_idle", 128'(s_busy[0]), 128'(0));

        txn(1'b1, 1'b0, 28'h0000005, '0, 6, 1);
        check_eq("rd5_data", t_rdat[0], d1);
        txn(1'b1, 1'b0, 28'h0000105, '0, 6, 1);
        check_eq("rd105_alias", t_rdat[0], d1);

        // Write-back then allocate: ready pulses 7 cycles apart, COOL request ignored.
        c0 = cyc_n;
        txn(1'b0, 1'b1, 28'h0000010, e1, 6, 1);
        r0 = c0 + t_rdy_at[0];
        check_eq("wb_cool_ignored", 128'(s_busy[0]), 128'(0));
        check_eq("wb_ready_count", 128'(t_nrdy[0]), 128'(1));
        c1 = cyc_n;
        txn(1'b1, 1'b0, 28'h0000020, '0, 6, 1);
        r1 = c1 + t_rdy_at[0];
        check_eq("wb_alloc_spacing", 128'(r1 - r0), 128'(7));

        // Abort: read dropped in cycle 2 never responds, idle by cycle 3.
        txn(1'b1, 1'b0, 28'h0000009, '0, 2, 2);
        check_eq("abort_no_ready", 128'(t_nrdy[0]), 128'(0));
        check_eq("abort_busy", 128'(s_busy[0]), 128'(0));
        txn(1'b0, 1'b1, 28'h0000009, f1, 6, 1);
        txn(1'b1, 1'b0, 28'h0000009, '0, 6, 1);
        check_eq("abort_then_rd", t_rdat[0], f1);

        check_eq("err_clear", 128'(s_err[0]), 128'(0));
        txn(1'b1, 1'b1, 28'h0000003, g1, 6, 1);
        check_eq("err_set", 128'(s_err[0]), 128'(1));
        txn(1'b1, 1'b0, 28'h0000003, '0, 6, 1);
        check_eq("both_is_write", t_rdat[0], g1);
        check_eq("err_sticky", 128'(s_err[0]), 128'(1));

        // Reset during a write to 0x7 leaves the old line in place.
        txn(1'b0, 1'b1, 28'h0000007, h1, 6, 1);
        cyc(1'b0, 1'b1, 28'h0000007, j1);
        cyc(1'b0, 1'b1, 28'h0000007, j1);
        async_reset();
        txn(1'b1, 1'b0, 28'h0000007, '0, 6, 1);
        check_eq("rst_no_commit", t_rdat[0], h1);
        check_eq("rst_err_cleared", 128'(s_err[0]), 128'(0));

        for (int t = 0; t < 250; t++) begin
            bit           rd, wr;
            logic [27:0]  a;
            logic [127:0] d;
            int           op, hold, gap;
            op   = $urandom_range(0, 15);
            rd   = (op == 0) || (op < 8);
            wr   = (op == 0) || (op >= 8);
            a    = rnd_addr();
            d    = rnd_line();
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 6;
            gap  = $urandom_range(0, 2);
            for (int i = 0; i < hold; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0) begin
                    a = rnd_addr();
                    d = rnd_line();
                end
                if ($urandom_range(0, 149) == 0) async_reset();
                else cyc(rd, wr, a, d);
            end
            for (int i = 0; i < gap; i++) begin
                cyc(1'b0, 1'b0, rnd_addr(), rnd_line());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
